bus_xfer_sequencer: RTL and testbench
=====================================

Name: bus_xfer_sequencer

Overview:
- Drives the "other end" of the shared 32-bit datapath bus: turns queued register-transfer requests (source code, destination code) into timed one-hot strobes.
- Source-select strobes (src_out) feed the bus encoder/multiplexer.
- Destination load enables (dst_in) go to register inputs.
- Sits between the control unit and the bus; serialises transfers so exactly one source drives the bus and exactly one destination latches per transfer.

Parameters:
- FIFO_DEPTH, 2, request queue entries (power of two, >=2)
- SETTLE_CYCLES, 1, cycles src_out is held before dst_in fires (>=1)

Ports:
- clock  in  1  system clock, all state on rising edge
- clear  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  queue can accept; transfer accepted when req_valid & req_ready on a clock edge
- req_src  in  5  bus source code
- req_dst  in  5  destination code
- src_out  out  32  one-hot bus source select; bit n = source code n
- dst_in  out  32  one-hot destination load enable; bit n = destination code n
- busy  out  1  queue non-empty or FSM not IDLE
- done  out  1  one-cycle pulse in the LOAD cycle of a completed transfer
- err  out  1  one-cycle pulse when an illegal request is dequeued and discarded

Behaviour:
- Reset (clear low, async):
  - src_out=0, dst_in=0, done=0, err=0, busy=0.
  - FIFO emptied; FSM=IDLE.
  - req_ready=1 from the first edge after release.
- Source codes: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C-sign-extended. Codes 24-31 are illegal sources.
- Destination codes: 0-15 R0-R15, 16 HI, 17 LO, 20 PC, 21 MDR, 24 MAR, 25 Y, 26 IR, 27 OutPort. All others are illegal destinations.
- FIFO:
  - req_ready = !full.
  - Push on accept. Pop when the FSM leaves IDLE or discards an entry.
  - Push and pop in the same cycle when full: the push is still refused, because req_ready is low that cycle. Occupancy cannot exceed FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DRIVE, LOAD.
  - IDLE: head entry present and legal -> register src/dst, go to DRIVE; src_out goes one-hot on the next cycle. Head illegal -> pop, err=1 next cycle, stay IDLE, outputs stay 0.
  - DRIVE: src_out one-hot held, dst_in=0. A counter counts SETTLE_CYCLES, then the FSM goes to LOAD.
  - LOAD: src_out still held; dst_in one-hot for exactly 1 cycle; done=1. If the next head is legal, go directly to DRIVE with the new src (no idle bubble); otherwise go to IDLE.
- Latency: request accepted into an empty, idle block at edge k.
  - Block is IDLE during cycle k+1; src_out is valid from k+2.
  - With SETTLE_CYCLES=1: dst_in and done are high in cycle k+3.
- Timing invariants:
  - src_out and dst_in are registered outputs, never combinational from req_*.
  - Neither output ever has more than one bit set.
  - dst_in is never asserted while src_out=0.
- src==dst (e.g. R3->R3) is legal and executed normally.
- Reset mid-transfer: all outputs drop immediately (async). The in-flight transfer and queued entries are lost; no done is issued.
- busy deasserts the cycle after the last LOAD or discard when the queue is empty.

Decomposition:
- Package bus_xfer_pkg holds:
  - source/destination code constants (SRC_R0..SRC_CSIGN, DST_MAR etc.)
  - FSM state typedef
  - functions is_legal_src / is_legal_dst
  - 5->32 one-hot decode function, the inverse of the bus encoder
- Sub-module: bus_xfer_fifo (parameterised synchronous FIFO with full/empty, async active-low clear).

Test Plan:
- Single transfer R2->R5 into idle block (SETTLE_CYCLES=1) -> src_out=0x0000_0004 from k+2; dst_in=0x0000_0020 and done=1 in k+3 only; busy low at k+4.
- Back-to-back PC->MAR then MDR->IR issued on consecutive cycles:
  - src_out goes 0x0010_0000 then 0x0020_0000.
  - dst_in pulses 0x0100_0000 then 0x0400_0000.
  - No IDLE cycle between the transfers.
- Fill queue with 3 requests while busy (FIFO_DEPTH=2) -> req_ready low once 2 are queued; the third is held off and accepted after the first pop; all three complete in order.
- Illegal requests src=28, dst=5 and src=3, dst=22 -> each produces err pulse=1 for one cycle; src_out and dst_in stay 0; no done; a following legal request executes normally.
- Assert clear low during DRIVE of HI->R1 -> src_out=0 and dst_in=0 immediately; busy=0 and no done; queue is empty after release.
- Random legal traffic with a scoreboard -> every cycle popcount(src_out)<=1 and popcount(dst_in)<=1; dst_in!=0 implies src_out!=0; done count equals legal request count.

Source files
------------

// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer sequencer: bus code map, FSM state,
// queued request layout and the code legality / one-hot decode helpers.
package bus_xfer_pkg;

   localparam int CODE_W = 5;
   localparam int BUS_W  = 32;

   // Bus source codes (what may drive the shared bus)
   localparam logic [4:0] SRC_R0      = 5'd0;
   localparam logic [4:0] SRC_R15     = 5'd15;
   localparam logic [4:0] SRC_HI      = 5'd16;
   localparam logic [4:0] SRC_LO      = 5'd17;
   localparam logic [4:0] SRC_ZHI     = 5'd18;
   localparam logic [4:0] SRC_ZLO     = 5'd19;
   localparam logic [4:0] SRC_PC      = 5'd20;
   localparam logic [4:0] SRC_MDR     = 5'd21;
   localparam logic [4:0] SRC_INPORT  = 5'd22;
   localparam logic [4:0] SRC_CSIGN   = 5'd23;

   // Destination codes (what may load from the shared bus)
   localparam logic [4:0] DST_R0      = 5'd0;
   localparam logic [4:0] DST_R15     = 5'd15;
   localparam logic [4:0] DST_HI      = 5'd16;
   localparam logic [4:0] DST_LO      = 5'd17;
   localparam logic [4:0] DST_PC      = 5'd20;
   localparam logic [4:0] DST_MDR     = 5'd21;
   localparam logic [4:0] DST_MAR     = 5'd24;
   localparam logic [4:0] DST_Y       = 5'd25;
   localparam logic [4:0] DST_IR      = 5'd26;
   localparam logic [4:0] DST_OUTPORT = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_LOAD  = 2'd2
   } xferState_e;

   typedef struct packed {
      logic [CODE_W-1:0] src;
      logic [CODE_W-1:0] dst;
   } xferReq_t;

   // Every code up to the sign-extended constant may drive the bus.
   function automatic logic is_legal_src(input logic [CODE_W-1:0] code);
      return (code <= SRC_CSIGN);
   endfunction

   // Register file plus the named special-purpose loads; the gaps are unused.
   function automatic logic is_legal_dst(input logic [CODE_W-1:0] code);
      logic legal;
      if (code <= DST_R15) begin
         legal = 1'b1;
      end else begin
         case (code)
            DST_HI, DST_LO, DST_PC, DST_MDR,
            DST_MAR, DST_Y, DST_IR, DST_OUTPORT: legal = 1'b1;
            default:                             legal = 1'b0;
         endcase
      end
      return legal;
   endfunction

   // 5->32 decode; the bus encoder performs the inverse mapping.
   function automatic logic [BUS_W-1:0] decodeOneHot(input logic [CODE_W-1:0] code);
      logic [BUS_W-1:0] vec;
      vec       = 32'd0;
      vec[code] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/bus_xfer_if.sv
// Request handshake and strobe outputs between the control unit (master)
// and the bus transfer sequencer (slave).
interface bus_xfer_if;
   import bus_xfer_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [CODE_W-1:0] req_src;
   logic [CODE_W-1:0] req_dst;
   logic [BUS_W-1:0]  src_out;
   logic [BUS_W-1:0]  dst_in;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_src, req_dst,
      input  req_ready, src_out, dst_in, busy, done, err
   );

   modport slave (
      input  req_valid, req_src, req_dst,
      output req_ready, src_out, dst_in, busy, done, err
   );

endinterface

// File: rtl/bus_xfer_fifo.sv
// Small synchronous FIFO holding pending transfer requests. Head entry is
// presented combinationally; a push while full is ignored.
module bus_xfer_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [PTR_W-1:0] wrPtr_r;
   logic [PTR_W-1:0] rdPtr_r;
   logic [PTR_W:0]   count_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             doPush_s;
   logic             doPop_s;

   assign full     = (count_r == CNT_FULL);
   assign empty    = (count_r == CNT_ZERO);
   assign doPush_s = push & ~full;
   assign doPop_s  = pop & ~empty;
   assign rdData   = mem_r[rdPtr_r];

   // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         wrPtr_r <= PTR_ZERO;
         rdPtr_r <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else begin
         if (doPush_s) wrPtr_r <= wrPtr_r + PTR_ONE;
         else          wrPtr_r <= wrPtr_r;
         if (doPop_s)  rdPtr_r <= rdPtr_r + PTR_ONE;
         else          rdPtr_r <= rdPtr_r;
         case ({doPush_s, doPop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are meaningless until written, so no reset.
   always_ff @(posedge clock) begin
      if (doPush_s) mem_r[wrPtr_r] <= wrData;
   end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Serialises queued register transfers onto the shared bus: one source strobe
// held while the bus settles, then a single-cycle destination load.
module bus_xfer_sequencer
   import bus_xfer_pkg::*;
#(
   parameter int FIFO_DEPTH    = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input logic       clock,
   input logic       clear,
   bus_xfer_if.slave bus
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   xferState_e        state_r;
   logic [CNT_W-1:0]  settleCnt_r;
   logic [CODE_W-1:0] dstCode_r;
   logic [BUS_W-1:0]  srcOut_r;
   logic [BUS_W-1:0]  dstIn_r;
   logic              done_r;
   logic              err_r;

   logic              fifoFull_s;
   logic              fifoEmpty_s;
   logic              pushReq_s;
   logic              popReq_s;
   logic              headLegal_s;
   xferReq_t          reqWord_s;
   xferReq_t          head_s;

   assign pushReq_s   = bus.req_valid & ~fifoFull_s;
   assign reqWord_s   = {bus.req_src, bus.req_dst};
   assign headLegal_s = is_legal_src(head_s.src) & is_legal_dst(head_s.dst);

   bus_xfer_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(xferReq_t))
   ) u_fifo (
      .clock  (clock),
      .clear  (clear),
      .push   (pushReq_s),
      .pop    (popReq_s),
      .wrData (reqWord_s),
      .rdData (head_s),
      .full   (fifoFull_s),
      .empty  (fifoEmpty_s)
   );

   // Dequeue whenever IDLE sees any head (claim or discard), or LOAD chains straight into a legal head.
   always_comb begin
      popReq_s = 1'b0;
      case (state_r)
         ST_IDLE: popReq_s = ~fifoEmpty_s;
         ST_LOAD: popReq_s = ~fifoEmpty_s & headLegal_s;
         default: popReq_s = 1'b0;
      endcase
   end

   // Transfer sequencing: claim legal heads, reject illegal ones, time settle and the one-cycle load.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_r     <= ST_IDLE;
         settleCnt_r <= CNT_ZERO;
         dstCode_r   <= 5'd0;
         srcOut_r    <= 32'd0;
         dstIn_r     <= 32'd0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         dstIn_r <= 32'd0;
         case (state_r)
            ST_IDLE: begin
               if (!fifoEmpty_s && headLegal_s) begin
                  state_r     <= ST_DRIVE;
                  srcOut_r    <= decodeOneHot(head_s.src);
                  dstCode_r   <= head_s.dst;
                  settleCnt_r <= CNT_ZERO;
               end else if (!fifoEmpty_s) begin
                  err_r    <= 1'b1;
                  srcOut_r <= 32'd0;
               end else begin
                  srcOut_r <= 32'd0;
               end
            end
            ST_DRIVE: begin
               if (settleCnt_r == CNT_LAST) begin
                  state_r <= ST_LOAD;
                  dstIn_r <= decodeOneHot(dstCode_r);
                  done_r  <= 1'b1;
               end else begin
                  settleCnt_r <= settleCnt_r + CNT_ONE;
               end
            end
            ST_LOAD: begin
               if (!fifoEmpty_s && headLegal_s) begin
                  state_r     <= ST_DRIVE;
                  srcOut_r    <= decodeOneHot(head_s.src);
                  dstCode_r   <= head_s.dst;
                  settleCnt_r <= CNT_ZERO;
               end else begin
                  state_r  <= ST_IDLE;
                  srcOut_r <= 32'd0;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               srcOut_r <= 32'd0;
            end
         endcase
      end
   end

   assign bus.req_ready = ~fifoFull_s;
   assign bus.src_out   = srcOut_r;
   assign bus.dst_in    = dstIn_r;
   assign bus.done      = done_r;
   assign bus.err       = err_r;
   assign bus.busy      = ~fifoEmpty_s | (state_r != ST_IDLE);

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: a transaction schedule model predicts every
// output per cycle; directed scenarios add hand-computed literal checks.
module tb_bus_xfer_sequencer;

   localparam int DEPTH  = 2;
   localparam int SETTLE = 1;
   localparam int TMAX   = 4096;

   logic clock = 1'b0;
   logic clear = 1'b1;
   always #5 clock = ~clock;

   bus_xfer_if bus();

   bus_xfer_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int t = 0;            // edges since reset release; outputs sampled after edge t are "time t"

   logic [31:0] expSrc  [TMAX];
   logic [31:0] expDst  [TMAX];
   bit          expDone [TMAX];
   bit          expErr  [TMAX];
   bit          expBusy [TMAX];
   int          expOcc  [TMAX];
   int nextLegal, nextDiscard, lastEnd, expDoneCnt, seenDoneCnt;
   bit checkOn = 1'b0;

   logic [4:0] dstList [12] = '{5'd0, 5'd3, 5'd7, 5'd15, 5'd16, 5'd17,
                                5'd20, 5'd21, 5'd24, 5'd25, 5'd26, 5'd27};

   always @(posedge clock or negedge clear)
      if (!clear) t <= 0;
      else        t <= t + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d actual=0x%08h expected=0x%08h", name, t, act, exp);
      end
   endtask

   function automatic bit srcOk(input logic [4:0] c);
      return c < 5'd24;
   endfunction

   function automatic bit dstOk(input logic [4:0] c);
      return (c < 5'd18) || (c == 5'd20) || (c == 5'd21) || (c >= 5'd24 && c <= 5'd27);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < TMAX; i++) begin
         expSrc[i] = 32'd0; expDst[i] = 32'd0; expDone[i] = 1'b0;
         expErr[i] = 1'b0;  expBusy[i] = 1'b0; expOcc[i] = 0;
      end
      nextLegal = 0; nextDiscard = 0; lastEnd = 0;
      expDoneCnt = 0; seenDoneCnt = 0;
   endtask

   // Schedule a request accepted at edge a: a single server that starts a legal
   // transfer one edge after it can see the head, chains straight after a LOAD,
   // and only rejects an illegal head from idle.
   task automatic modelAccept(input int a, input logic [4:0] s, input logic [4:0] d);
      int start, stop, popEdge;
      bit legal;
      legal = srcOk(s) && dstOk(d);
      if (legal) begin
         start = (a + 1 > nextLegal) ? a + 1 : nextLegal;
         for (int x = start; x <= start + SETTLE; x++)
            if (x < TMAX) expSrc[x] = 32'd1 << s;
         stop = start + SETTLE;
         if (stop < TMAX) begin
            expDst[stop]  = 32'd1 << d;
            expDone[stop] = 1'b1;
         end
         popEdge     = start;
         nextLegal   = stop + 1;
         nextDiscard = stop + 2;
         expDoneCnt++;
      end else begin
         popEdge = (a + 1 > nextDiscard) ? a + 1 : nextDiscard;
         if (popEdge < TMAX) expErr[popEdge] = 1'b1;
         stop        = popEdge - 1;
         nextLegal   = popEdge + 1;
         nextDiscard = popEdge + 1;
      end
      for (int x = a; x <= stop; x++)        if (x < TMAX) expBusy[x] = 1'b1;
      for (int x = a; x < popEdge; x++)      if (x < TMAX) expOcc[x]++;
      if (popEdge > lastEnd) lastEnd = popEdge;
      if (stop > lastEnd)    lastEnd = stop;
   endtask

   // Per-cycle comparison against the schedule model plus the strobe invariants.
   always @(negedge clock) begin
      if (checkOn && clear) begin
         if (t >= TMAX) begin
            check("time_budget", 32'(t), 32'(TMAX - 1));
         end else begin
            check("src_out",   bus.src_out,          expSrc[t]);
            check("dst_in",    bus.dst_in,           expDst[t]);
            check("done",      32'(bus.done),        32'(expDone[t]));
            check("err",       32'(bus.err),         32'(expErr[t]));
            check("busy",      32'(bus.busy),        32'(expBusy[t]));
            check("req_ready", 32'(bus.req_ready),   32'(expOcc[t] < DEPTH));
            check("src_onehot", 32'($countones(bus.src_out) <= 1), 32'd1);
            check("dst_onehot", 32'($countones(bus.dst_in) <= 1),  32'd1);
            check("dst_needs_src", 32'((bus.dst_in != 32'd0) && (bus.src_out == 32'd0)), 32'd0);
         end
         if (bus.done === 1'b1) seenDoneCnt++;
      end
   end

   // Called just after a negedge; holds the request until the model says it is taken.
   task automatic send(input logic [4:0] s, input logic [4:0] d, output int acc);
      bit got;
      got = 1'b0;
      acc = -1;
      bus.req_valid = 1'b1;
      bus.req_src   = s;
      bus.req_dst   = d;
      for (int w = 0; w < 100 && !got; w++) begin
         if (t < TMAX && expOcc[t] < DEPTH) begin
            got = 1'b1;
            acc = t + 1;
            modelAccept(t + 1, s, d);
         end
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      if (!got) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitTime(input int n);
      for (int w = 0; w < 1000 && t < n; w++) @(negedge clock);
      if (t < n) check("wait_timeout", 32'(t), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0d", t);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k, k2, k3, kc, kd;
      bus.req_valid = 1'b0;
      bus.req_src   = 5'd0;
      bus.req_dst   = 5'd0;
      modelReset();

      // Reset state
      #1 clear = 1'b0;
      #3;
      check("rst_src",  bus.src_out,        32'd0);
      check("rst_dst",  bus.dst_in,         32'd0);
      check("rst_done", 32'(bus.done),      32'd0);
      check("rst_err",  32'(bus.err),       32'd0);
      check("rst_busy", 32'(bus.busy),      32'd0);
      #8 clear = 1'b1;
      checkOn = 1'b1;
      @(negedge clock);

      // Single transfer R2 -> R5
      send(5'd2, 5'd5, k);
      waitTime(k + 1);
      check("t1_src_drive", bus.src_out, 32'h0000_0004);
      check("t1_dst_drive", bus.dst_in,  32'h0000_0000);
      waitTime(k + 2);
      check("t1_src_load",  bus.src_out, 32'h0000_0004);
      check("t1_dst_load",  bus.dst_in,  32'h0000_0020);
      check("t1_done",      32'(bus.done), 32'd1);
      waitTime(k + 3);
      check("t1_busy_low",  32'(bus.busy), 32'd0);

      // Back-to-back PC -> MAR, MDR -> IR
      waitTime(lastEnd + 2);
      send(5'd20, 5'd24, k);
      send(5'd21, 5'd26, k2);
      check("b2b_accept", 32'(k2), 32'(k + 1));
      waitTime(k + 1);
      check("b2b_src1", bus.src_out, 32'h0010_0000);
      waitTime(k + 2);
      check("b2b_dst1", bus.dst_in,  32'h0100_0000);
      waitTime(k + 3);
      check("b2b_src2", bus.src_out, 32'h0020_0000);
      check("b2b_nobubble", 32'(bus.busy), 32'd1);
      waitTime(k + 4);
      check("b2b_dst2", bus.dst_in,  32'h0400_0000);
      check("b2b_done2", 32'(bus.done), 32'd1);

      // Queue fills while busy; third request is held off
      waitTime(lastEnd + 2);
      send(5'd1, 5'd2, k);
      send(5'd3, 5'd4, k2);
      send(5'd5, 5'd6, k3);
      check("fill_ready_low", 32'(bus.req_ready), 32'd0);
      send(5'd7, 5'd8, kc);
      check("fill_third_accept", 32'(kc), 32'(k + 4));
      waitTime(lastEnd + 2);

      // Illegal requests are discarded with an err pulse
      send(5'd28, 5'd5, k);
      waitTime(k + 1);
      check("ill1_err", 32'(bus.err), 32'd1);
      check("ill1_src", bus.src_out, 32'd0);
      send(5'd3, 5'd22, k2);
      waitTime(k2 + 1);
      check("ill2_err",  32'(bus.err),  32'd1);
      check("ill2_dst",  bus.dst_in,    32'd0);
      check("ill2_done", 32'(bus.done), 32'd0);
      send(5'd1, 5'd2, kd);
      waitTime(kd + 1);
      check("ill_after_src", bus.src_out, 32'h0000_0002);
      waitTime(lastEnd + 2);

      // Reset during DRIVE of HI -> R1
      send(5'd16, 5'd1, k);
      waitTime(k + 1);
      check("mid_src_drive", bus.src_out, 32'h0001_0000);
      #2 clear = 1'b0;
      modelReset();
      #1;
      check("mid_src_zero",  bus.src_out,   32'd0);
      check("mid_dst_zero",  bus.dst_in,    32'd0);
      check("mid_busy_zero", 32'(bus.busy), 32'd0);
      check("mid_done_zero", 32'(bus.done), 32'd0);
      @(negedge clock);
      @(negedge clock);
      #2 clear = 1'b1;
      @(negedge clock);
      check("post_rst_busy",  32'(bus.busy),      32'd0);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_nodone", 32'(seenDoneCnt),  32'd0);
      send(5'd4, 5'd25, k);
      waitTime(k + 2);
      check("post_rst_dst", bus.dst_in, 32'h0200_0000);

      // Random legal traffic
      for (int i = 0; i < 40; i++) begin
         logic [4:0] rs, rd;
         int gap;
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clock);
         rs = 5'($urandom_range(0, 23));
         rd = dstList[$urandom_range(0, 11)];
         send(rs, rd, k);
      end
      waitTime(lastEnd + 3);
      check("done_count", 32'(seenDoneCnt), 32'(expDoneCnt));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
